pc_branch_predict_unit: RTL
===========================

// Module: pc_branch_predict_unit
// PURPOSE
//  Parametrised successor to the fetch-stage program counter. Holds the PC and predicts the next fetch
//  address from a direct-mapped branch target buffer (BTB) with saturating counters. Redirects on EX-stage
//  jumps and MEM-stage branch mispredicts, and drives the IF/ID, ID/EX and EX/MEM flush lines.
//  Sits between the hazard unit (PCWrite) and the instruction-memory request path.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  BTB_ENTRIES  16             BTB depth; power of two, >=2; IDX_W = log2(BTB_ENTRIES)
//  CTR_BITS     2              saturating counter width, >=1
//  MISP_CNT_W   16             width of the mispredict statistics counter
// PORTS
//  CLK              in   1   clock, rising edge
//  nRST             in   1   asynchronous active-low reset
//  PCWrite          in   1   1 = advance/redirect this cycle; 0 = hold PC, no BTB update, no flush
//  pc               out  32  current fetch address (registered)
//  pred_taken       out  1   prediction for current pc (travels down pipe with instr)
//  pred_target      out  32  predicted next pc for current pc (travels down pipe)
//  jump_valid       in   1   EX stage holds a JAL/JALR
//  jump_pc          in   32  pc of that jump
//  jump_target      in   32  resolved jump target
//  jump_pred_target in   32  pred_target carried with that jump
//  br_valid         in   1   MEM stage holds a resolved conditional branch
//  br_pc            in   32  pc of that branch
//  br_taken         in   1   actual outcome
//  br_target        in   32  actual taken target
//  br_pred_taken    in   1   pred_taken carried with that branch
//  br_pred_target   in   32  pred_target carried with that branch
//  flush_IF_ID      out  1   combinational flush of IF/ID latch
//  flush_ID_EX      out  1   combinational flush of ID/EX latch
//  flush_EX_MEM     out  1   combinational flush of EX/MEM latch
//  misp_count       out  MISP_CNT_W  saturating count of redirects (branch + jump)
// BEHAVIOUR
//  Reset (async, nRST=0): pc=RESET_PC; all BTB valid=0; counters=2^(CTR_BITS-1)-1 (weak not-taken);
//   misp_count=0. Flush outputs follow combinational rules below (0 with no valid inputs).
//  Lookup (combinational on pc): idx=pc[IDX_W+1:2], tag=pc[31:IDX_W+2]. hit=valid[idx]&&tag match.
//   pred_taken=hit&&ctr[idx][CTR_BITS-1]; pred_target=pred_taken ? target[idx] : pc+4 (mod 2^32).
//  br_misp = br_valid && (br_taken!=br_pred_taken || (br_taken && br_target!=br_pred_target)).
//  jmp_misp = jump_valid && (jump_target!=jump_pred_target).
//  Next-pc priority, applied only when PCWrite=1 (upstream holds EX/MEM inputs while PCWrite=0):
//   1 br_misp  -> pc<=br_taken ? br_target : br_pc+4; flush_IF_ID=flush_ID_EX=flush_EX_MEM=1
//   2 jmp_misp -> pc<=jump_target; flush_IF_ID=flush_ID_EX=1 (EX/MEM not flushed)
//   3 else     -> pc<=pred_target; no flush
//  PCWrite=0: pc, BTB, misp_count hold; all flush outputs 0.
//  BTB update (PCWrite=1, at the clock edge, independent of priority; branch and jump updates may
//   both occur in one cycle; if same index, the branch update wins):
//   branch hit: ctr sat-inc if taken, sat-dec if not; target<=br_target if taken.
//   branch miss & taken: allocate valid=1, tag, target, ctr=2^(CTR_BITS-1) (weak taken).
//   branch miss & not taken: no change.
//   jump (hit or miss): valid=1, tag, target=jump_target, ctr=all ones.
//  Read/write same index in same cycle: lookup sees old contents; new contents visible next cycle.
//  misp_count += 1 per cycle with br_misp or jmp_misp and PCWrite=1; saturates at all ones.
//   A cycle with both br_misp and jmp_misp counts as one.
//  Latency: redirect visible on pc one cycle after the event; flush asserted in the event cycle.
//  pc wraps: 32'hFFFF_FFFC + 4 = 32'h0. Mid-operation reset restores reset state immediately.
// TESTING
//  T1 reset, no branches, PCWrite=1 x4 -> pc 0,4,8,C; pred_taken=0; flushes 0; misp_count=0
//  T2 br_valid pc=0x10 taken tgt=0x40 pred_taken=0 -> 3 flushes high that cycle; next pc=0x40;
//     next fetch of 0x10 gives pred_taken=1, pred_target=0x40; misp_count=1
//  T3 same branch not-taken twice (CTR_BITS=2) -> ctr 2->1->0; pred_taken=0 after first; pc redirect to 0x14
//  T4 jump_valid tgt=0x80 with pred 0x84 and br_misp same cycle -> br redirect wins, 3 flushes, count+1
//  T5 PCWrite=0 with br_misp pending -> pc holds, flushes 0, BTB unchanged; PCWrite=1 next -> redirect
//  T6 pc=0xFFFF_FFFC no hit -> next pc 0x0; nRST pulse mid-run -> pc=RESET_PC, BTB all invalid

Source files
------------

// File: rtl/pc_branch_predict_unit.sv
// Fetch-stage program counter with a direct-mapped BTB and saturating counters.
// Redirects on EX-stage jump and MEM-stage branch mispredicts and drives pipeline flushes.
module pc_branch_predict_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          CTR_BITS    = 2,
  parameter int          MISP_CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  PCWrite,
  output logic [31:0]           pc,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  input  logic                  jump_valid,
  input  logic [31:0]           jump_pc,
  input  logic [31:0]           jump_target,
  input  logic [31:0]           jump_pred_target,
  input  logic                  br_valid,
  input  logic [31:0]           br_pc,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic                  br_pred_taken,
  input  logic [31:0]           br_pred_target,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EX,
  output logic                  flush_EX_MEM,
  output logic [MISP_CNT_W-1:0] misp_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_WNT + CTR_ONE;
  localparam logic [MISP_CNT_W-1:0] MISP_MAX = '1;
  localparam logic [MISP_CNT_W-1:0] MISP_ONE = MISP_CNT_W'(1);

  function automatic logic [CTR_BITS-1:0] f_ctr_inc(input logic [CTR_BITS-1:0] c);
    if (c == CTR_MAX) return c;
    else              return c + CTR_ONE;
  endfunction

  function automatic logic [CTR_BITS-1:0] f_ctr_dec(input logic [CTR_BITS-1:0] c);
    if (c == '0) return c;
    else         return c - CTR_ONE;
  endfunction

  logic                r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]    r_tag    [BTB_ENTRIES];
  logic [31:0]         r_target [BTB_ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] w_idx, w_br_idx, w_jmp_idx;
  logic [TAG_W-1:0] w_tag, w_br_tag, w_jmp_tag;
  logic             w_hit, w_br_hit;
  logic             w_br_misp, w_jmp_misp;
  logic [31:0]      w_next_pc;
  logic             w_flush_if_id, w_flush_id_ex, w_flush_ex_mem;
  logic             w_unused_ok;

  assign w_idx     = pc[IDX_W+1:2];
  assign w_tag     = pc[31:IDX_W+2];
  assign w_br_idx  = br_pc[IDX_W+1:2];
  assign w_br_tag  = br_pc[31:IDX_W+2];
  assign w_jmp_idx = jump_pc[IDX_W+1:2];
  assign w_jmp_tag = jump_pc[31:IDX_W+2];
  assign w_unused_ok = ^{jump_pc[1:0]};

  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_br_hit    = r_valid[w_br_idx] && (r_tag[w_br_idx] == w_br_tag);
  assign pred_taken  = w_hit && r_ctr[w_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? r_target[w_idx] : (pc + 32'd4);

  assign w_br_misp  = br_valid && ((br_taken != br_pred_taken) ||
                                   (br_taken && (br_target != br_pred_target)));
  assign w_jmp_misp = jump_valid && (jump_target != jump_pred_target);

  // Next-pc selection and flush generation; branch redirect outranks jump redirect.
  always_comb begin
    w_next_pc      = pred_target;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_ex_mem = 1'b0;
    if (PCWrite) begin
      if (w_br_misp) begin
        w_next_pc      = br_taken ? br_target : (br_pc + 32'd4);
        w_flush_if_id  = 1'b1;
        w_flush_id_ex  = 1'b1;
        w_flush_ex_mem = 1'b1;
      end else if (w_jmp_misp) begin
        w_next_pc     = jump_target;
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
      end else begin
        w_next_pc = pred_target;
      end
    end else begin
      w_next_pc = pc;
    end
  end

  assign flush_IF_ID  = w_flush_if_id;
  assign flush_ID_EX  = w_flush_id_ex;
  assign flush_EX_MEM = w_flush_ex_mem;

  // Program counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        pc <= RESET_PC;
    else if (PCWrite) pc <= w_next_pc;
    else              pc <= pc;
  end

  // Saturating redirect counter; a cycle with both mispredicts counts once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      misp_count <= '0;
    end else if (PCWrite && (w_br_misp || w_jmp_misp) && (misp_count != MISP_MAX)) begin
      misp_count <= misp_count + MISP_ONE;
    end else begin
      misp_count <= misp_count;
    end
  end

  // BTB training; the branch write comes last so it wins a same-index collision.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'h0000_0000;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (PCWrite) begin
      if (jump_valid) begin
        r_valid[w_jmp_idx]  <= 1'b1;
        r_tag[w_jmp_idx]    <= w_jmp_tag;
        r_target[w_jmp_idx] <= jump_target;
        r_ctr[w_jmp_idx]    <= CTR_MAX;
      end
      if (br_valid) begin
        if (w_br_hit) begin
          r_valid[w_br_idx] <= 1'b1;
          r_tag[w_br_idx]   <= w_br_tag;
          r_ctr[w_br_idx]   <= br_taken ? f_ctr_inc(r_ctr[w_br_idx])
                                        : f_ctr_dec(r_ctr[w_br_idx]);
          if (br_taken) r_target[w_br_idx] <= br_target;
        end else if (br_taken) begin
          r_valid[w_br_idx]  <= 1'b1;
          r_tag[w_br_idx]    <= w_br_tag;
          r_target[w_br_idx] <= br_target;
          r_ctr[w_br_idx]    <= CTR_WT;
        end
      end
    end
  end

endmodule
